// File: rtl/phys_mem_ctrl.sv
// Sequences strobe-less, tag-compared CPU requests into async SRAM read/write cycles; PHYS_MEM_WRITE_FWD_EN adds write-to-read forwarding.
// Busy cycles: read RD_WAIT+2, write WR_SETUP+WR_PULSE+3, out-of-range 2, repeat 0; mem_busy stalls the CPU and inputs are ignored outside IDLE.
module phys_mem_ctrl #(
  parameter int ADDR_WIDTH = 20,
  parameter int RD_WAIT    = 2,
  parameter int WR_SETUP   = 1,
  parameter int WR_PULSE   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_data_in,
  input  logic                  mem_is_write,
  output logic [31:0]           mem_data_out,
  output logic                  mem_busy,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_data_o,
  output logic                  sram_data_oe,
  input  logic [31:0]           sram_data_i,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);

  typedef enum logic [2:0] {IDLE, RD, WS, WP, WH, DONE} state_t;
  localparam int CW = 8;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic                  tag_valid;
  logic [29:0]           tag_addr;
  logic                  tag_write;
  logic [31:0]           tag_wdata;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic [31:0]           rdata;
  logic                  match;
  logic                  in_range;
  logic                  fwd_hit;

  // Write data only matters to the tag for writes; a read is identified by address alone.
  assign match = tag_valid && (tag_addr == mem_addr[31:2]) && (tag_write == mem_is_write) &&
                 (!mem_is_write || (tag_wdata == mem_data_in));
  assign in_range     = (mem_addr >> (ADDR_WIDTH + 2)) == 32'd0;
  assign mem_busy     = (state != IDLE) || !match;
  assign mem_data_out = rdata;
  assign sram_addr    = lat_addr;
  assign sram_data_o  = lat_wdata;

`ifdef PHYS_MEM_WRITE_FWD_EN
  logic        fwd_valid;
  logic [29:0] fwd_addr;
  logic [31:0] fwd_data;

  assign fwd_hit = fwd_valid && !mem_is_write && (fwd_addr == mem_addr[31:2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_valid <= 1'b0;
      fwd_addr  <= '0;
      fwd_data  <= '0;
    end else if (state == IDLE && !match && mem_is_write && in_range) begin
      fwd_valid <= 1'b1;
      fwd_addr  <= mem_addr[31:2];
      fwd_data  <= mem_data_in;
    end
  end
`else
  assign fwd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!match) begin
        if (!in_range || fwd_hit) state_nxt = DONE;
        else if (mem_is_write)    state_nxt = WS;
        else                      state_nxt = RD;
      end
      RD:      if (cnt == '0) state_nxt = DONE;
      WS:      if (cnt == '0) state_nxt = WP;
      WP:      if (cnt == '0) state_nxt = WH;
      WH:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode from state alone so reset releases them in the same cycle.
  always_comb begin
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_data_oe = 1'b0;
    case (state)
      RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
      end
      WS, WH: begin
        sram_ce_n    = 1'b0;
        sram_data_oe = 1'b1;
      end
      WP: begin
        sram_ce_n    = 1'b0;
        sram_we_n    = 1'b0;
        sram_data_oe = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      tag_valid <= 1'b0;
      tag_addr  <= '0;
      tag_write <= 1'b0;
      tag_wdata <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: if (!match) begin
          tag_valid <= 1'b0;
          tag_addr  <= mem_addr[31:2];
          tag_write <= mem_is_write;
          tag_wdata <= mem_data_in;
          lat_addr  <= mem_addr[ADDR_WIDTH+1:2];
          lat_wdata <= mem_data_in;
          if (mem_is_write) cnt <= CW'(WR_SETUP - 1);
          else              cnt <= CW'(RD_WAIT - 1);
`ifdef PHYS_MEM_WRITE_FWD_EN
          if (fwd_hit)                           rdata <= fwd_data;
          else if (mem_is_write && in_range)     rdata <= mem_data_in;
          else if (!mem_is_write && !in_range)   rdata <= '0;
`else
          if (!mem_is_write && !in_range) rdata <= '0;
`endif
        end
        RD: begin
          if (cnt == '0) rdata <= sram_data_i;
          else           cnt   <= cnt - 1'b1;
        end
        WS: begin
          if (cnt == '0) cnt <= CW'(WR_PULSE - 1);
          else           cnt <= cnt - 1'b1;
        end
        WP:      if (cnt != '0) cnt <= cnt - 1'b1;
        DONE:    tag_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_phys_mem_ctrl.sv
// Bench for phys_mem_ctrl: directed vector table, multi-cycle corner sequences and a randomized run against a request-level model.
module tb_phys_mem_ctrl;

`ifdef PHYS_MEM_WRITE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_is_write;
  logic [31:0] mem_data_out;
  logic        mem_busy;
  logic [19:0] sram_addr;
  logic [31:0] sram_data_o;
  logic        sram_data_oe;
  logic [31:0] sram_data_i = 32'h0BAD_0BAD;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  phys_mem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_is_write (mem_is_write),
    .mem_data_out (mem_data_out),
    .mem_busy     (mem_busy),
    .sram_addr    (sram_addr),
    .sram_data_o  (sram_data_o),
    .sram_data_oe (sram_data_oe),
    .sram_data_i  (sram_data_i),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // SRAM device: unwritten words read back as {12'h5A5, word}.
  logic [31:0] sram_mem [logic [19:0]];

  function automatic logic [31:0] def_val(input logic [19:0] w);
    return {12'h5A5, w};
  endfunction

  always @(negedge clk) begin
    if (!sram_ce_n && !sram_oe_n)
      sram_data_i = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : def_val(sram_addr);
    else
      sram_data_i = 32'h0BAD_0BAD;
  end

  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_data_oe) sram_mem[sram_addr] = sram_data_o;

  // Running strobe totals; requests take differences across their busy window.
  int ce_tot = 0, we_tot = 0, oe_tot = 0, doe_tot = 0, ovl_tot = 0;
  logic [19:0] strobe_addr = '0;
  always @(negedge clk) begin
    if (!sram_ce_n) begin
      ce_tot++;
      strobe_addr = sram_addr;
    end
    if (!sram_we_n)   we_tot++;
    if (!sram_oe_n)   oe_tot++;
    if (sram_data_oe) doe_tot++;
    if (sram_data_oe && !sram_oe_n) ovl_tot++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_done(inout int busy);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (mem_busy) busy++;
      else          done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout: mem_busy still 1 after %0d cycles, expected 0", busy);
    end
  endtask

  int s_ce, s_we, s_oe, s_doe;
  task automatic snap();
    s_ce = ce_tot; s_we = we_tot; s_oe = oe_tot; s_doe = doe_tot;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic w,
                        output int busy, output int ce, output int we, output int oe, output int doe);
    @(posedge clk);
    #1;
    mem_addr = a; mem_data_in = d; mem_is_write = w;
    snap();
    busy = 0;
    wait_done(busy);
    ce = ce_tot - s_ce; we = we_tot - s_we; oe = oe_tot - s_oe; doe = doe_tot - s_doe;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    int          busy;
    int          busy_fwd;
    int          ce;
    int          ce_fwd;
    logic [31:0] data;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  // Request-level reference model state for the random phase.
  logic [31:0] mm [logic [19:0]];
  logic        m_lv, m_lw, m_fv;
  logic [31:0] m_la, m_ld;
  logic [19:0] m_fw;

  initial begin
    int b, ce, we, oe, doe, eb, ece;
    logic [31:0] a, d;
    logic w, same, inr, got_we;
    logic [19:0] word;
    logic [31:0] exp_d;

    vt[0]  = '{32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 6, 6, 4, 4, 32'h0};
    vt[1]  = '{32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 0, 0, 0, 0, 32'h0};
    vt[2]  = '{32'h0000_0100, 32'h0,         1'b0, 4, 2, 2, 0, 32'hDEAD_BEEF};
    vt[3]  = '{32'h0000_0100, 32'h0,         1'b0, 0, 0, 0, 0, 32'hDEAD_BEEF};
    vt[4]  = '{32'h8000_0000, 32'h0,         1'b0, 2, 2, 0, 0, 32'h0};
    vt[5]  = '{32'h8000_0000, 32'h1111_1111, 1'b1, 2, 2, 0, 0, 32'h0};
    vt[6]  = '{32'h0000_0108, 32'h0,         1'b0, 4, 4, 2, 2, 32'h5A50_0042};
    vt[7]  = '{32'h0000_0104, 32'hCAFE_F00D, 1'b1, 6, 6, 4, 4, 32'h0};
    vt[8]  = '{32'h0000_0104, 32'hCAFE_F00E, 1'b1, 6, 6, 4, 4, 32'h0};
    vt[9]  = '{32'h0000_0104, 32'h0,         1'b0, 4, 2, 2, 0, 32'hCAFE_F00E};
    vt[10] = '{32'h0040_0000, 32'h0,         1'b0, 2, 2, 0, 0, 32'h0};
    vt[11] = '{32'h003F_FFFC, 32'h0,         1'b0, 4, 4, 2, 2, 32'h5A5F_FFFF};
    vt[12] = '{32'h003F_FFFC, 32'h0123_4567, 1'b1, 6, 6, 4, 4, 32'h0};
    vt[13] = '{32'h003F_FFFC, 32'h0,         1'b0, 4, 2, 2, 0, 32'h0123_4567};

    // Reset state with a read of address 0 presented.
    rst = 1'b0; mem_addr = '0; mem_data_in = '0; mem_is_write = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(mem_busy), 32'd1);
    chk("rst_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'hE);
    chk("rst_data_out", mem_data_out, 32'h0);
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    snap();
    b = 0;
    wait_done(b);
    chk("init_read_busy", 32'(b), 32'd4);
    chk("init_read_ce", 32'(ce_tot - s_ce), 32'd2);
    chk("init_read_data", mem_data_out, 32'h5A50_0000);

    for (int i = 0; i < NV; i++) begin
      do_req(vt[i].addr, vt[i].wdata, vt[i].wr, b, ce, we, oe, doe);
      eb  = FWD ? vt[i].busy_fwd : vt[i].busy;
      ece = FWD ? vt[i].ce_fwd : vt[i].ce;
      chk($sformatf("vec%0d_busy", i), 32'(b), 32'(eb));
      chk($sformatf("vec%0d_ce", i), 32'(ce), 32'(ece));
      chk($sformatf("vec%0d_we", i), 32'(we), (vt[i].wr && ece > 0) ? 32'd2 : 32'd0);
      chk($sformatf("vec%0d_oe", i), 32'(oe), vt[i].wr ? 32'd0 : 32'(ece));
      chk($sformatf("vec%0d_data_oe", i), 32'(doe), vt[i].wr ? 32'(ece) : 32'd0);
      if (ece > 0) chk($sformatf("vec%0d_sram_addr", i), 32'(strobe_addr), 32'(vt[i].addr[21:2]));
      if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), mem_data_out, vt[i].data);
    end

    // Address change mid-read: old access finishes, then a new read of word 0x42.
    @(posedge clk); #1;
    mem_addr = 32'h104; mem_is_write = 1'b0;
    snap();
    b = 0;
    @(negedge clk);
    if (mem_busy) b++;
    @(posedge clk); #1 mem_addr = 32'h108;
    wait_done(b);
    chk("chg_busy", 32'(b), 32'd8);
    chk("chg_ce", 32'(ce_tot - s_ce), 32'd4);
    chk("chg_sram_addr", 32'(strobe_addr), 32'h42);
    chk("chg_rdata", mem_data_out, 32'h5A50_0042);

    // Reset during the WE pulse, then the held write re-executes.
    @(posedge clk); #1;
    mem_addr = 32'h300; mem_data_in = 32'h0BAD_CAFE; mem_is_write = 1'b1;
    got_we = 1'b0;
    for (int i = 0; i < 20 && !got_we; i++) begin
      @(posedge clk); #1;
      got_we = !sram_we_n;
    end
    chk("wp_reached", 32'(got_we), 32'd1);
    rst = 1'b0;
    #1;
    chk("wp_rst_strobes", {29'd0, sram_ce_n, sram_we_n, sram_data_oe}, 32'h6);
    chk("wp_rst_busy", 32'(mem_busy), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    snap();
    b = 0;
    wait_done(b);
    chk("rewrite_busy", 32'(b), 32'd6);
    chk("rewrite_we", 32'(we_tot - s_we), 32'd2);

    // Reset again with a read of the same word: forwarding state must be gone.
    @(posedge clk); #1;
    rst = 1'b0; mem_is_write = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    snap();
    b = 0;
    wait_done(b);
    chk("post_rst_read_busy", 32'(b), 32'd4);
    chk("post_rst_read_ce", 32'(ce_tot - s_ce), 32'd2);
    chk("post_rst_read_data", mem_data_out, 32'h0BAD_CAFE);

    // Randomized phase on a fresh address region.
    m_lv = 1'b1; m_la = 32'h300; m_lw = 1'b0; m_ld = 32'h0BAD_CAFE; m_fv = 1'b0; m_fw = '0;
    for (int n = 0; n < 150; n++) begin
      if (n > 0 && $urandom_range(0, 3) == 0) begin
        a = m_la; d = m_ld; w = m_lw;
      end else begin
        a = ($urandom_range(0, 7) == 0) ? 32'h8000_1000 : 32'h1000 + 32'($urandom_range(0, 3)) * 4;
        d = 32'hA000_0000 + 32'($urandom_range(0, 2));
        w = 1'($urandom_range(0, 1));
      end
      word = a[21:2];
      inr  = (a >> 22) == 32'd0;
      same = m_lv && (a[31:2] == m_la[31:2]) && (w == m_lw) && (!w || d == m_ld);
      if (same) begin
        eb = 0; ece = 0;
      end else if (!inr) begin
        eb = 2; ece = 0;
      end else if (w) begin
        eb = 6; ece = 4;
        mm[word] = d;
        if (FWD) begin m_fv = 1'b1; m_fw = word; end
      end else if (FWD && m_fv && m_fw == word) begin
        eb = 2; ece = 0;
      end else begin
        eb = 4; ece = 2;
      end
      exp_d = !inr ? 32'h0 : (mm.exists(word) ? mm[word] : def_val(word));
      m_lv = 1'b1; m_la = a; m_ld = d; m_lw = w;

      do_req(a, d, w, b, ce, we, oe, doe);
      chk($sformatf("rnd%0d_busy", n), 32'(b), 32'(eb));
      chk($sformatf("rnd%0d_ce", n), 32'(ce), 32'(ece));
      chk($sformatf("rnd%0d_we", n), 32'(we), (w && ece > 0) ? 32'd2 : 32'd0);
      if (!w) chk($sformatf("rnd%0d_rdata", n), mem_data_out, exp_d);
    end

    chk("oe_data_oe_overlap", 32'(ovl_tot), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phys_mem_ctrl.md
Name: phys_mem_ctrl

Overview:
- Physical memory controller downstream of the CPU's MMU physical-memory port.
- Turns the strobe-less CPU request (addr / write-data / is_write held stable while busy) into timed cycles on one external asynchronous 1M x 32 SRAM.
- Returns read data and a busy flag.
- Requests are detected by comparing the current inputs against a tag of the last completed access.

Parameters:
- ADDR_WIDTH, 20, SRAM word-address width; word address = mem_addr[ADDR_WIDTH+1:2].
- RD_WAIT, 2, cycles CE/OE held low before read data is sampled (>=1).
- WR_SETUP, 1, cycles address/data driven with WE high before the WE pulse (>=1).
- WR_PULSE, 2, cycles WE held low (>=1).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous active-low reset.
- mem_addr  in  32  physical byte address from the MMU; bits [1:0] ignored.
- mem_data_in  in  32  write data from the MMU.
- mem_is_write  in  1  1 = write request, 0 = read request.
- mem_data_out  out  32  read data; valid when mem_busy=0 and the request is a read.
- mem_busy  out  1  combinational; high while the current request has not completed.
- sram_addr  out  ADDR_WIDTH  SRAM word address.
- sram_data_o  out  32  SRAM write data.
- sram_data_oe  out  1  1 = drive the SRAM data bus; the top-level tristate uses it.
- sram_data_i  in  32  SRAM bus read value.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; tag_valid=0; rdata=0; mem_data_out=0.
  - sram_ce_n=sram_oe_n=sram_we_n=1; sram_data_oe=0; sram_addr=0; sram_data_o=0.
  - Reset mid-access aborts immediately with all strobes deasserted; no partial write is retried.
- Tag:
  - Holds {addr[31:2], is_write, wdata}.
  - match = tag_valid & (addr[31:2] equal) & (is_write equal) & (!is_write | wdata equal).
- mem_busy = (state != IDLE) | !match.
  - Rises in the same cycle an input change creates a mismatch.
- In range: mem_addr[31:ADDR_WIDTH+2] == 0.
- States:
  - IDLE: strobes inactive (ce_n/oe_n/we_n=1, data_oe=0). On mismatch, latch addr/wdata/is_write into the working registers and the tag (tag_valid cleared until completion), then:
    - read in range -> RD, counter=RD_WAIT-1.
    - write in range -> WS, counter=WR_SETUP-1.
    - out of range -> DONE; read data 0, write discarded.
  - RD: ce_n=0, oe_n=0, sram_addr=latched. At counter==0, capture sram_data_i into rdata -> DONE; else decrement.
  - WS: ce_n=0, we_n=1, data_oe=1, sram_addr and sram_data_o latched. At counter==0 -> WP with counter=WR_PULSE-1.
  - WP: as WS but we_n=0. At counter==0 -> WH.
  - WH: ce_n=0, we_n=1, data_oe=1 (hold time). -> DONE.
  - DONE: strobes inactive; tag_valid=1; -> IDLE.
- Latency (busy-high cycles, counting the detect cycle):
  - Read: RD_WAIT+2.
  - Write: WR_SETUP+WR_PULSE+3.
  - Out of range: 2.
  - Unchanged request: 0.
- mem_data_out = rdata. It holds after write completion; it is only defined for reads.
- Input changes while state != IDLE are ignored. The latched access completes, then the mismatch starts a new access at IDLE.
- An identical repeated write (same addr, same data) is not re-issued; it is idempotent.
- An identical repeated read returns the cached rdata without an SRAM cycle.
  - Safe because every SRAM write passes through this block and changes the tag.
- sram_data_oe and sram_oe_n are never both active.

Optional Feature:
- Macro PHYS_MEM_WRITE_FWD_EN.
- Defined:
  - A write also loads rdata with wdata and keeps fwd_addr = addr[31:2].
  - A following read whose addr[31:2] equals fwd_addr completes via DONE with no SRAM cycle (busy 2 cycles).
  - Any other write updates fwd_addr.
  - Reset clears the forwarding valid bit.
- Undefined: every read with a tag mismatch performs an SRAM cycle.

Test Plan:
- Reset with rst=0, inputs addr=0 read: mem_busy=1, all strobes high, mem_data_out=0. Release: one read completes in RD_WAIT+2=4 cycles, then busy=0.
- Write addr 0x00000100, data 0xDEADBEEF: sram_addr=0x40, WE low exactly 2 cycles, data_oe high 4 cycles; busy high 6 cycles, then stays 0 while the request is held.
- Read 0x00000100 with SRAM model returning 0xDEADBEEF: CE/OE low 2 cycles, mem_data_out=0xDEADBEEF, busy 4 cycles. A held read shows no further CE activity.
- Read 0x80000000 (out of range): no CE assertion, busy 2 cycles, mem_data_out=0. Write 0x80000000: no WE pulse.
- Change addr from 0x104 to 0x108 during RD: the 0x104 access completes unchanged, then a new read of word 0x42 starts; total busy 8 cycles.
- Assert rst=0 during WP: we_n=1 and data_oe=0 the same cycle. After release, re-presenting the same write re-executes it (tag invalid). With PHYS_MEM_WRITE_FWD_EN, write 0x200=0x12345678 then read 0x200 gives 0x12345678, busy 2 cycles, no CE/OE.
